// File: rtl/anton_bcd_display_pkg.sv
// Shared definitions for the BCD display block: FSM encoding, digit count,
// iteration bound, 7-segment patterns and the double-dabble add-3 helper.
package anton_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;

    localparam int NUM_DIGITS = 3;
    localparam int ITER_LAST  = 7;

    // Active-high segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
    function automatic logic [11:0] bcd_add3(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/anton_bcd_display_if.sv
// Valid/ready product handshake from the multiplier stage.
interface anton_bcd_display_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/anton_bcd_display_seg7.sv
// Combinational BCD digit to 7-segment decoder with a blanking override.
module anton_seg7_decode
    import anton_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pattern lookup; non-decimal codes and blanking both give a dark digit.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/anton_bcd_display.sv
// Accepts an 8-bit product, converts it to three BCD digits with a
// one-iteration-per-cycle double-dabble engine, holds the result and scans
// it onto a multiplexed 3-digit 7-segment display with leading-zero blanking.
module anton_bcd_display
    import anton_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    anton_bcd_display_if.slave        up,
    output logic                      busy,
    output logic                      bcd_valid,
    output logic [11:0]               bcd,
    output logic [1:0]                digit_sel,
    output logic [6:0]                seg
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] scratch_q, scratch_d;
    logic [2:0]  iter_q, iter_d;
    logic [11:0] bcd_q, bcd_d;
    logic        bcd_valid_q, bcd_valid_d;
    logic [11:0] scratch_adj;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_sel_q, digit_sel_d;

    logic [3:0] cur_digit;
    logic       cur_blank;

    assign scratch_adj = bcd_add3(scratch_q);

    // Conversion FSM and datapath next-state.
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (up.in_valid) begin
                    state_d   = ST_CONV;
                    shift_d   = up.in_data;
                    scratch_d = '0;
                    iter_d    = '0;
                end
            end
            ST_CONV: begin
                {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                iter_d               = iter_q + 3'd1;
                if (iter_q == 3'(ITER_LAST)) begin
                    bcd_d       = scratch_d;
                    bcd_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Conversion state registers; reset aborts any conversion in flight.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            scratch_q   <= '0;
            iter_q      <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            iter_q      <= iter_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    // Free-running scan prescaler; the digit advances on each wrap.
    always_comb begin
        presc_d     = presc_q + PW'(1);
        digit_sel_d = digit_sel_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d     = '0;
            digit_sel_d = (digit_sel_q == 2'd2) ? 2'd0 : digit_sel_q + 2'd1;
        end
    end

    // Scan registers, independent of the conversion FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            digit_sel_q <= '0;
        end else begin
            presc_q     <= presc_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    // Select the active digit and apply leading-zero blanking.
    always_comb begin
        cur_digit = bcd_q[3:0];
        cur_blank = 1'b0;
        case (digit_sel_q)
            2'd1: begin
                cur_digit = bcd_q[7:4];
                cur_blank = (bcd_q[11:4] == 8'h00);
            end
            2'd2: begin
                cur_digit = bcd_q[11:8];
                cur_blank = (bcd_q[11:8] == 4'h0);
            end
            default: begin
                cur_digit = bcd_q[3:0];
                cur_blank = 1'b0;
            end
        endcase
    end

    anton_seg7_decode u_seg7 (
        .digit (cur_digit),
        .blank (cur_blank),
        .seg   (seg)
    );

    assign up.in_ready = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_CONV);
    assign bcd_valid   = bcd_valid_q;
    assign bcd         = bcd_q;
    assign digit_sel   = digit_sel_q;

endmodule
